// File: rtl/v_wb_arb.sv
// v_wb_arb: VRF writeback arbiter (VMEM over VALU, optional VALU anti-starvation via V_WB_ARB_STARVE_EN); ports: valu_*/vmem_* producer handshakes, vwb_stall_i, registered vwb_* write, chk_addr_i/chk_hazard_o probe
module v_wb_arb #(
  parameter int VREG_DW      = 256,
  parameter int VREG_AW      = 5,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valu_valid_i,
  output logic               valu_ready_o,
  input  logic [VREG_AW-1:0] valu_addr_i,
  input  logic [VREG_DW-1:0] valu_data_i,
  input  logic               vmem_valid_i,
  output logic               vmem_ready_o,
  input  logic [VREG_AW-1:0] vmem_addr_i,
  input  logic [VREG_DW-1:0] vmem_data_i,
  input  logic               vwb_stall_i,
  output logic               vwb_en_o,
  output logic [VREG_AW-1:0] vwb_addr_o,
  output logic [VREG_DW-1:0] vwb_data_o,
  input  logic [VREG_AW-1:0] chk_addr_i,
  output logic               chk_hazard_o
);
  if ((1 << CNT_W) <= STARVE_LIMIT) begin : g_bad_cnt_w
    $error("CNT_W too narrow for STARVE_LIMIT");
  end
  logic               open;
  logic               force_valu;
  logic               valu_win;
  logic               vmem_win;
  logic               en_q, en_d;
  logic [VREG_AW-1:0] addr_q, addr_d;
  logic [VREG_DW-1:0] data_q, data_d;
`ifdef V_WB_ARB_STARVE_EN
  logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
  assign force_valu = starve_cnt_q == CNT_W'(STARVE_LIMIT);
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (open)
      starve_cnt_d = (valu_valid_i && vmem_win)
                   ? (force_valu ? starve_cnt_q : starve_cnt_q + CNT_W'(1))
                   : '0;
  end
  always_ff @(posedge clk)
    if (rst) starve_cnt_q <= '0;
    else     starve_cnt_q <= starve_cnt_d;
`else
  assign force_valu = 1'b0;
`endif
  assign open         = !rst && !vwb_stall_i;
  assign vmem_win     = open && vmem_valid_i && !(valu_valid_i && force_valu);
  assign valu_win     = open && valu_valid_i && (!vmem_valid_i || force_valu);
  assign valu_ready_o = valu_win;
  assign vmem_ready_o = vmem_win;
  always_comb begin
    en_d   = open ? (valu_win || vmem_win) : en_q;
    addr_d = vmem_win ? vmem_addr_i : valu_win ? valu_addr_i : addr_q;
    data_d = vmem_win ? vmem_data_i : valu_win ? valu_data_i : data_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      en_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      en_q   <= en_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  assign vwb_en_o     = en_q;
  assign vwb_addr_o   = addr_q;
  assign vwb_data_o   = data_q;
  assign chk_hazard_o = (valu_valid_i && valu_addr_i == chk_addr_i)
                     || (vmem_valid_i && vmem_addr_i == chk_addr_i)
                     || (en_q && addr_q == chk_addr_i);
endmodule

// File: tb/tb_v_wb_arb.sv
// tb_v_wb_arb: randomized self-checking bench for v_wb_arb against a behavioural model
module tb_v_wb_arb;
  localparam int LIM = 4;
  logic         clk = 0;
  logic         rst = 1;
  logic         valu_valid_i = 0, vmem_valid_i = 0, vwb_stall_i = 0;
  logic [4:0]   valu_addr_i = 0, vmem_addr_i = 0, chk_addr_i = 0;
  logic [255:0] valu_data_i = 0, vmem_data_i = 0;
  logic         valu_ready_o, vmem_ready_o, vwb_en_o, chk_hazard_o;
  logic [4:0]   vwb_addr_o;
  logic [255:0] vwb_data_o;
  v_wb_arb dut (
    .clk(clk), .rst(rst),
    .valu_valid_i(valu_valid_i), .valu_ready_o(valu_ready_o), .valu_addr_i(valu_addr_i), .valu_data_i(valu_data_i),
    .vmem_valid_i(vmem_valid_i), .vmem_ready_o(vmem_ready_o), .vmem_addr_i(vmem_addr_i), .vmem_data_i(vmem_data_i),
    .vwb_stall_i(vwb_stall_i), .vwb_en_o(vwb_en_o), .vwb_addr_o(vwb_addr_o), .vwb_data_o(vwb_data_o),
    .chk_addr_i(chk_addr_i), .chk_hazard_o(chk_hazard_o)
  );
  always #5 clk = ~clk;
  int pass = 0, total = 0;
  logic         m_en = 0;
  logic [4:0]   m_addr = 0;
  logic [255:0] m_data = 0;
  int           m_cnt = 0;
  logic         last_vw = 0, last_mw = 0;
  logic [260:0] exp_q[$], obs_q[$];
  function automatic logic [255:0] rnd256();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  // Who should win this cycle, straight from the arbitration rules.
  task automatic model_eval(output logic vw, output logic mw);
    logic f;
`ifdef V_WB_ARB_STARVE_EN
    f = m_cnt == LIM;
`else
    f = 0;
`endif
    vw = 0; mw = 0;
    if (!rst && !vwb_stall_i) begin
      if (valu_valid_i && vmem_valid_i) begin vw = f; mw = !f; end
      else begin vw = valu_valid_i; mw = vmem_valid_i; end
    end
  endtask
  function automatic logic exp_hazard();
    return (valu_valid_i && valu_addr_i == chk_addr_i) || (vmem_valid_i && vmem_addr_i == chk_addr_i) || (m_en && m_addr == chk_addr_i);
  endfunction
  task automatic tick();
    logic vw, mw;
    model_eval(vw, mw);
    last_vw = vw; last_mw = mw;
    if (vwb_en_o && !vwb_stall_i && !rst) obs_q.push_back({vwb_addr_o, vwb_data_o});
    if (m_en && !vwb_stall_i && !rst) exp_q.push_back({m_addr, m_data});
    if (rst) begin m_en = 0; m_addr = 0; m_data = 0; m_cnt = 0; end
    else if (!vwb_stall_i) begin
      m_en = vw || mw;
      if (mw) begin m_addr = vmem_addr_i; m_data = vmem_data_i; end
      else if (vw) begin m_addr = valu_addr_i; m_data = valu_data_i; end
      m_cnt = (valu_valid_i && mw) ? ((m_cnt + 1 > LIM) ? LIM : m_cnt + 1) : 0;
    end
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    rst = 1; valu_valid_i = 1; vmem_valid_i = 1; valu_addr_i = 4; vmem_addr_i = 9; chk_addr_i = 4;
    tick(); tick(); #1;
    total++; if (vwb_en_o !== 1'b0) $display("FAIL reset_en got=%b exp=0", vwb_en_o); else pass++;
    total++; if (vwb_addr_o !== 5'd0) $display("FAIL reset_addr got=%0d exp=0", vwb_addr_o); else pass++;
    total++; if (vwb_data_o !== 256'd0) $display("FAIL reset_data got=%h exp=0", vwb_data_o); else pass++;
    total++; if ({valu_ready_o, vmem_ready_o} !== 2'b00) $display("FAIL reset_ready got=%b exp=00", {valu_ready_o, vmem_ready_o}); else pass++;
    total++; if (chk_hazard_o !== 1'b1) $display("FAIL reset_hazard_hit got=%b exp=1", chk_hazard_o); else pass++;
    chk_addr_i = 6; #1;
    total++; if (chk_hazard_o !== 1'b0) $display("FAIL reset_hazard_miss got=%b exp=0", chk_hazard_o); else pass++;
    valu_valid_i = 0; vmem_valid_i = 0; tick(); rst = 0;
  endtask
  task automatic test_single_valu();
    logic [255:0] d;
    d = {32{8'hA5}};
    valu_valid_i = 1; valu_addr_i = 3; valu_data_i = d; #1;
    total++; if ({valu_ready_o, vmem_ready_o} !== 2'b10) $display("FAIL single_ready got=%b exp=10", {valu_ready_o, vmem_ready_o}); else pass++;
    tick(); valu_valid_i = 0; #1;
    total++; if (vwb_en_o !== 1'b1) $display("FAIL single_en got=%b exp=1", vwb_en_o); else pass++;
    total++; if (vwb_addr_o !== 5'd3) $display("FAIL single_addr got=%0d exp=3", vwb_addr_o); else pass++;
    total++; if (vwb_data_o !== d) $display("FAIL single_data got=%h exp=%h", vwb_data_o, d); else pass++;
    tick(); #1;
    total++; if (vwb_en_o !== 1'b0) $display("FAIL single_idle_en got=%b exp=0", vwb_en_o); else pass++;
  endtask
  task automatic test_contention();
    logic ev;
    rst = 1; tick(); rst = 0;
    valu_valid_i = 1; vmem_valid_i = 1;
    for (int i = 0; i < 10; i++) begin
      valu_addr_i = 5'(i); vmem_addr_i = 5'(i + 16); vmem_data_i = rnd256(); #1;
`ifdef V_WB_ARB_STARVE_EN
      ev = (i % (LIM + 1)) == LIM;
`else
      ev = 0;
`endif
      total++; if (valu_ready_o !== ev || vmem_ready_o !== !ev)
        $display("FAIL contention_ready cyc=%0d got=%b%b exp=%b%b", i, valu_ready_o, vmem_ready_o, ev, !ev); else pass++;
      tick();
    end
    valu_valid_i = 0; vmem_valid_i = 0; tick();
  endtask
  task automatic test_stall();
    logic [255:0] d;
    d = rnd256();
    valu_valid_i = 1; valu_addr_i = 10; valu_data_i = rnd256();
    vmem_valid_i = 1; vmem_addr_i = 11; vmem_data_i = d;
    tick();
    vmem_addr_i = 12; vmem_data_i = rnd256(); vwb_stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({valu_ready_o, vmem_ready_o} !== 2'b00) $display("FAIL stall_ready cyc=%0d got=%b exp=00", i, {valu_ready_o, vmem_ready_o}); else pass++;
      total++; if (vwb_en_o !== 1'b1 || vwb_addr_o !== 5'd11 || vwb_data_o !== d)
        $display("FAIL stall_hold cyc=%0d got=%b/%0d exp=1/11", i, vwb_en_o, vwb_addr_o); else pass++;
      tick();
    end
    obs_q.delete(); exp_q.delete();
    vwb_stall_i = 0; #1;
    total++; if (vmem_ready_o !== 1'b1) $display("FAIL stall_resume_ready got=%b exp=1", vmem_ready_o); else pass++;
    tick();
    total++; if (obs_q.size() != 1 || obs_q[0] !== {5'd11, d}) $display("FAIL stall_commit got_n=%0d exp_n=1", obs_q.size()); else pass++;
    for (int i = 0; i < 6; i++) begin
      logic vw, mw;
      vmem_data_i = rnd256(); #1;
      model_eval(vw, mw);
      total++; if (valu_ready_o !== vw || vmem_ready_o !== mw)
        $display("FAIL stall_after_ready cyc=%0d got=%b%b exp=%b%b", i, valu_ready_o, vmem_ready_o, vw, mw); else pass++;
      tick();
    end
    valu_valid_i = 0; vmem_valid_i = 0; tick(); tick();
  endtask
  task automatic test_hazard();
    valu_valid_i = 1; valu_addr_i = 7; tick(); valu_valid_i = 0;
    chk_addr_i = 7; #1;
    total++; if (chk_hazard_o !== 1'b1) $display("FAIL hazard_out_hit got=%b exp=1", chk_hazard_o); else pass++;
    chk_addr_i = 8; #1;
    total++; if (chk_hazard_o !== 1'b0) $display("FAIL hazard_out_miss got=%b exp=0", chk_hazard_o); else pass++;
    vmem_valid_i = 1; vmem_addr_i = 8; vwb_stall_i = 1; #1;
    total++; if (chk_hazard_o !== 1'b1) $display("FAIL hazard_vmem_hit got=%b exp=1", chk_hazard_o); else pass++;
    vmem_valid_i = 0; vwb_stall_i = 0; tick(); tick();
  endtask
  task automatic test_reset_midstream();
    logic ev;
    rst = 1; tick(); rst = 0;
    valu_valid_i = 1; vmem_valid_i = 1; valu_addr_i = 1; vmem_addr_i = 2;
    tick(); tick();
    rst = 1; #1;
    total++; if ({valu_ready_o, vmem_ready_o} !== 2'b00) $display("FAIL midrst_ready got=%b exp=00", {valu_ready_o, vmem_ready_o}); else pass++;
    obs_q.delete(); exp_q.delete();
    tick(); rst = 0; valu_valid_i = 0; vmem_valid_i = 0; #1;
    total++; if (vwb_en_o !== 1'b0 || vwb_addr_o !== 5'd0 || vwb_data_o !== 256'd0)
      $display("FAIL midrst_out got=%b/%0d exp=0/0", vwb_en_o, vwb_addr_o); else pass++;
    total++; if (obs_q.size() != 0) $display("FAIL midrst_no_commit got_n=%0d exp_n=0", obs_q.size()); else pass++;
    valu_valid_i = 1; vmem_valid_i = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
`ifdef V_WB_ARB_STARVE_EN
      ev = i == LIM;
`else
      ev = 0;
`endif
      total++; if (valu_ready_o !== ev) $display("FAIL midrst_cnt cyc=%0d got=%b exp=%b", i, valu_ready_o, ev); else pass++;
      tick();
    end
    valu_valid_i = 0; vmem_valid_i = 0; tick(); tick();
  endtask
  task automatic test_same_addr();
    logic [255:0] d1, d2;
    d1 = {64{4'h1}}; d2 = {64{4'h2}};
    obs_q.delete(); exp_q.delete();
    valu_valid_i = 1; vmem_valid_i = 1; valu_addr_i = 5; vmem_addr_i = 5; valu_data_i = d2; vmem_data_i = d1; #1;
    total++; if (vmem_ready_o !== 1'b1) $display("FAIL same_first got=%b exp=1", vmem_ready_o); else pass++;
    tick(); vmem_valid_i = 0; #1;
    total++; if (valu_ready_o !== 1'b1) $display("FAIL same_second got=%b exp=1", valu_ready_o); else pass++;
    tick(); valu_valid_i = 0; tick(); tick();
    total++; if (obs_q.size() != 2 || obs_q[0] !== {5'd5, d1} || obs_q[1] !== {5'd5, d2})
      $display("FAIL same_order got_n=%0d exp_n=2", obs_q.size()); else pass++;
  endtask
  task automatic test_random();
    logic vw, mw;
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 400; i++) begin
      if (!valu_valid_i || last_vw) begin valu_valid_i = $urandom_range(0, 2) != 0; valu_addr_i = 5'($urandom()); valu_data_i = rnd256(); end
      if (!vmem_valid_i || last_mw) begin vmem_valid_i = $urandom_range(0, 2) != 0; vmem_addr_i = 5'($urandom()); vmem_data_i = rnd256(); end
      vwb_stall_i = $urandom_range(0, 4) == 0;
      chk_addr_i = $urandom_range(0, 1) ? valu_addr_i : 5'($urandom());
      #1;
      model_eval(vw, mw);
      total++; if (valu_ready_o !== vw || vmem_ready_o !== mw)
        $display("FAIL rnd_ready cyc=%0d got=%b%b exp=%b%b", i, valu_ready_o, vmem_ready_o, vw, mw); else pass++;
      total++; if (vwb_en_o !== m_en || (m_en && (vwb_addr_o !== m_addr || vwb_data_o !== m_data)))
        $display("FAIL rnd_out cyc=%0d got=%b/%0d exp=%b/%0d", i, vwb_en_o, vwb_addr_o, m_en, m_addr); else pass++;
      total++; if (chk_hazard_o !== exp_hazard()) $display("FAIL rnd_hazard cyc=%0d got=%b exp=%b", i, chk_hazard_o, exp_hazard()); else pass++;
      tick();
    end
    valu_valid_i = 0; vmem_valid_i = 0; vwb_stall_i = 0; tick(); tick();
    total++; if (obs_q.size() != exp_q.size()) $display("FAIL rnd_commit_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) $display("FAIL rnd_commit idx=%0d got_addr=%0d exp_addr=%0d", i, obs_q[i][260:256], exp_q[i][260:256]); else pass++;
    end
  endtask
  initial begin
    test_reset();
    test_single_valu();
    test_contention();
    test_stall();
    test_hazard();
    test_reset_midstream();
    test_same_addr();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
